mac_sequencer: RTL and testbench

//  Multi-cycle controller for the matrix-MAC extension: computes C = A x B for NxN (N=1..4) row-major matrices.

---
 rtl/mac_sequencer_pkg.sv | 31 +++
 rtl/mac_sequencer_if.sv | 49 ++++
 rtl/mac_seq_addr_gen.sv | 39 +++
 rtl/mac_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mac_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_sequencer_pkg.sv
// mac_sequencer_pkg
//   Shared definitions for the matrix-MAC sequencer slice: FSM state
//   encodings, the largest supported matrix dimension and the shift-add
//   helper used to form row offsets (x * N) without a multiplier.
//   No ports.
package mac_sequencer_pkg;

  // Largest supported N, and the width of the i/j/k counters it implies.
  localparam int MAX_DIM = 4;
  localparam int CNT_W   = $clog2(MAX_DIM);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAC   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // x * n for x in 0..3 and n in 1..4, built from the set bits of n.
  // The largest product is 12, so four bits are enough.
  function automatic logic [3:0] mul_by_n(input logic [1:0] x, input logic [2:0] n);
    logic [3:0] acc;
    acc = 4'd0;
    if (n[0]) acc = acc + {2'b00, x};
    if (n[1]) acc = acc + {1'b0, x, 1'b0};
    if (n[2]) acc = acc + {x, 2'b00};
    return acc;
  endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if
//   Bundles the decode-side request and the sequencer's memory/MAC/pipeline
//   controls into one interface.
//   Request  : start, dim, a_base, b_base, c_base
//   Controls : rd_en, a_addr, b_addr, mac_clr, mac_en, wr_en, c_addr
//   Status   : stall, busy, done (and cycle_cnt when MAC_SEQ_PERF_CNT_EN
//              is defined)
//   Modports : slave  = the sequencer itself
//              master = whoever issues requests and consumes controls
interface mac_sequencer_if #(parameter int ADDR_W = 8);

  logic              start;
  logic [1:0]        dim;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic [ADDR_W-1:0] c_base;
  logic              rd_en;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic              mac_clr;
  logic              mac_en;
  logic              wr_en;
  logic [ADDR_W-1:0] c_addr;
  logic              stall;
  logic              busy;
  logic              done;
`ifdef MAC_SEQ_PERF_CNT_EN
  logic [15:0]       cycle_cnt;
`endif

  modport slave (
    input  start, dim, a_base, b_base, c_base,
    output rd_en, a_addr, b_addr, mac_clr, mac_en, wr_en, c_addr,
    output stall, busy, done
`ifdef MAC_SEQ_PERF_CNT_EN
    , output cycle_cnt
`endif
  );

  modport master (
    output start, dim, a_base, b_base, c_base,
    input  rd_en, a_addr, b_addr, mac_clr, mac_en, wr_en, c_addr,
    input  stall, busy, done
`ifdef MAC_SEQ_PERF_CNT_EN
    , input cycle_cnt
`endif
  );

endinterface

// File: rtl/mac_seq_addr_gen.sv
// mac_seq_addr_gen
//   Combinational operand/result address generation for C = A x B with
//   row-major NxN matrices. Sums wrap modulo 2^ADDR_W.
//   Inputs : a_base, b_base, c_base (latched bases), n (N, 1..4), i, j, k
//   Outputs: a_addr = a_base + i*N + k
//            b_addr = b_base + k*N + j
//            c_addr = c_base + i*N + j
module mac_seq_addr_gen
  import mac_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] c_base,
  input  logic [2:0]        n,
  input  logic [1:0]        i,
  input  logic [1:0]        j,
  input  logic [1:0]        k,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [ADDR_W-1:0] c_addr
);

  logic [ADDR_W-1:0] i_row;
  logic [ADDR_W-1:0] k_row;

  // The row offsets i*N and k*N are shared between the A, B and C
  // addresses. Each one is widened to the address width before the sum so
  // that the carry out of the top bit is simply dropped.
  always_comb begin
    i_row  = ADDR_W'(mul_by_n(i, n));
    k_row  = ADDR_W'(mul_by_n(k, n));
    a_addr = a_base + i_row + ADDR_W'(k);
    b_addr = b_base + k_row + ADDR_W'(j);
    c_addr = c_base + i_row + ADDR_W'(j);
  end

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer
//   Multi-cycle controller for the matrix-MAC extension. For each element
//   C[i][j], it issues N operand reads, waits one cycle for the last operand
//   pair, and then writes the accumulator back. The core pipeline is
//   stalled while the operation is busy.
//   Ports: clk, rst (synchronous, active high), bus (mac_sequencer_if.slave)
//   Optional: MAC_SEQ_PERF_CNT_EN adds bus.cycle_cnt, the busy-cycle count
//             of the most recent operation.
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  mac_sequencer_if.slave bus
);

  state_t            state;
  logic [CNT_W-1:0]  i_cnt;
  logic [CNT_W-1:0]  j_cnt;
  logic [CNT_W-1:0]  k_cnt;
  logic [1:0]        dim_q;
  logic [ADDR_W-1:0] a_base_q;
  logic [ADDR_W-1:0] b_base_q;
  logic [ADDR_W-1:0] c_base_q;
  logic              rd_en_q;
  logic              mac_clr_q;
  logic              mac_en_q;
  logic              wr_en_q;
  logic              busy_q;
  logic              done_q;
  logic [2:0]        n_val;
  logic [ADDR_W-1:0] a_raw;
  logic [ADDR_W-1:0] b_raw;
  logic [ADDR_W-1:0] c_raw;

  assign n_val = {1'b0, dim_q} + 3'd1;

  mac_seq_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .a_base (a_base_q),
    .b_base (b_base_q),
    .c_base (c_base_q),
    .n      (n_val),
    .i      (i_cnt),
    .j      (j_cnt),
    .k      (k_cnt),
    .a_addr (a_raw),
    .b_addr (b_raw),
    .c_addr (c_raw)
  );

  // Sequencer FSM. Each control output is computed together with the state
  // it belongs to, so outputs change in the same cycle as the state. The
  // request is latched on acceptance, and later changes on the request
  // lines are ignored until the next start in IDLE. mac_en trails rd_en by
  // the one-cycle read latency. An element takes N MAC cycles, one DRAIN
  // cycle and one WRITE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      i_cnt     <= '0;
      j_cnt     <= '0;
      k_cnt     <= '0;
      dim_q     <= '0;
      a_base_q  <= '0;
      b_base_q  <= '0;
      c_base_q  <= '0;
      rd_en_q   <= 1'b0;
      mac_clr_q <= 1'b0;
      mac_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      mac_en_q <= rd_en_q;
      wr_en_q  <= 1'b0;
      done_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            dim_q     <= bus.dim;
            a_base_q  <= bus.a_base;
            b_base_q  <= bus.b_base;
            c_base_q  <= bus.c_base;
            i_cnt     <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            rd_en_q   <= 1'b1;
            mac_clr_q <= 1'b1;
            busy_q    <= 1'b1;
            state     <= ST_MAC;
          end
        end
        ST_MAC: begin
          mac_clr_q <= 1'b0;
          if (k_cnt == dim_q) begin
            rd_en_q <= 1'b0;
            state   <= ST_DRAIN;
          end else begin
            k_cnt <= k_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          wr_en_q <= 1'b1;
          state   <= ST_WRITE;
        end
        ST_WRITE: begin
          if ((j_cnt == dim_q) && (i_cnt == dim_q)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else begin
            if (j_cnt == dim_q) begin
              j_cnt <= '0;
              i_cnt <= i_cnt + 1'b1;
            end else begin
              j_cnt <= j_cnt + 1'b1;
            end
            k_cnt     <= '0;
            rd_en_q   <= 1'b1;
            mac_clr_q <= 1'b1;
            state     <= ST_MAC;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          rd_en_q   <= 1'b0;
          mac_clr_q <= 1'b0;
          busy_q    <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MAC_SEQ_PERF_CNT_EN
  logic [15:0] cycle_cnt_q;

  // Busy-cycle counter. It restarts from zero on an accepted start and
  // counts every cycle in which busy is high. Because nothing else changes
  // it, it holds the count from the last operation until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
    end else if ((state == ST_IDLE) && bus.start) begin
      cycle_cnt_q <= '0;
    end else if (busy_q) begin
      cycle_cnt_q <= cycle_cnt_q + 16'd1;
    end
  end

  assign bus.cycle_cnt = cycle_cnt_q;
`endif

  // Addresses are only meaningful while busy. Forcing them to zero
  // otherwise keeps the memory ports quiet in IDLE and DONE.
  assign bus.a_addr  = busy_q ? a_raw : '0;
  assign bus.b_addr  = busy_q ? b_raw : '0;
  assign bus.c_addr  = busy_q ? c_raw : '0;
  assign bus.rd_en   = rd_en_q;
  assign bus.mac_clr = mac_clr_q;
  assign bus.mac_en  = mac_en_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.busy    = busy_q;
  assign bus.stall   = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer
//   Directed bench for mac_sequencer. A negedge monitor logs the read
//   pairs, write addresses and pulse counts. Each scenario then compares
//   the log with hand-computed address tables and cycle counts.
//   Define MAC_SEQ_PERF_CNT_EN to also check cycle_cnt.
module tb_mac_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_at_edge = 1'b1;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int start_cyc = 0;
  int first_busy, done_cyc, first_rd, first_macen;
  int n_clr, n_macen, n_busy, n_done;
  int macen_err = 0;
  int stall_err = 0;
  int idle_err  = 0;
  logic prev_rd = 1'b0;
  logic [15:0] rd_log[$];
  logic [7:0]  wr_log[$];

  logic [15:0] exp_rd2 [8] = '{16'h0010, 16'h0112, 16'h0011, 16'h0113,
                                16'h0210, 16'h0312, 16'h0211, 16'h0313};

  mac_sequencer_if #(.ADDR_W(8)) bus ();

  mac_sequencer #(.ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Remember whether reset was sampled on the last rising edge. The
  // mac_en-follows-rd_en rule does not hold across a reset edge.
  always @(posedge clk) rst_at_edge <= rst;

  // Negedge monitor. It logs every read pair, write address and pulse, and
  // counts any cycle where the standing invariants break: mac_en echoes the
  // previous rd_en, stall equals busy, and all controls and addresses are
  // quiet while not busy.
  always @(negedge clk) begin
    cyc++;
    if (bus.rd_en) begin
      rd_log.push_back({bus.a_addr, bus.b_addr});
      if (first_rd < 0) first_rd = cyc;
    end
    if (bus.mac_clr) n_clr++;
    if (bus.mac_en) begin
      n_macen++;
      if (first_macen < 0) first_macen = cyc;
    end
    if (bus.wr_en) wr_log.push_back(bus.c_addr);
    if (bus.busy) begin
      n_busy++;
      if (first_busy < 0) first_busy = cyc;
    end
    if (bus.done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (!rst_at_edge && (bus.mac_en !== prev_rd)) macen_err++;
    if (bus.stall !== bus.busy) stall_err++;
    if (!bus.busy && ({bus.rd_en, bus.wr_en, bus.mac_clr, bus.mac_en} != 4'b0 ||
        bus.a_addr != 8'h00 || bus.b_addr != 8'h00 || bus.c_addr != 8'h00))
      idle_err++;
    prev_rd = bus.rd_en;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearLog();
    rd_log.delete();
    wr_log.delete();
    n_clr = 0; n_macen = 0; n_busy = 0; n_done = 0;
    first_busy = -1; done_cyc = -1; first_rd = -1; first_macen = -1;
  endtask

  // Present a one-cycle start, then scramble the request lines. The
  // sequencer must work only from the values it latched.
  task automatic applyStimulus(input logic [1:0] d, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] c);
    @(posedge clk);
    #1;
    bus.dim = d; bus.a_base = a; bus.b_base = b; bus.c_base = c;
    bus.start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.dim = 2'd3; bus.a_base = 8'hA5; bus.b_base = 8'h5A; bus.c_base = 8'hC3;
  endtask

  task automatic waitDone(input string tag, input int budget);
    for (int t = 0; t < budget && n_done == 0; t++) @(negedge clk);
    checkOutput({tag, "_done_seen"}, (n_done != 0), 1);
    repeat (8) @(negedge clk);
  endtask

  task automatic checkN2(input string tag);
    checkOutput({tag, "_rd_cnt"}, rd_log.size(), 8);
    for (int e = 0; e < 8 && e < rd_log.size(); e++)
      checkOutput($sformatf("%s_rd%0d", tag, e), rd_log[e], exp_rd2[e]);
    checkOutput({tag, "_wr_cnt"}, wr_log.size(), 4);
    for (int e = 0; e < 4 && e < wr_log.size(); e++)
      checkOutput($sformatf("%s_wr%0d", tag, e), wr_log[e], 8'h20 + 8'(e));
    checkOutput({tag, "_clr_cnt"}, n_clr, 4);
    checkOutput({tag, "_macen_cnt"}, n_macen, 8);
    checkOutput({tag, "_busy_cnt"}, n_busy, 16);
    checkOutput({tag, "_busy_rise"}, first_busy - start_cyc, 2);
    checkOutput({tag, "_done_at"}, done_cyc - first_busy, 16);
    checkOutput({tag, "_done_cnt"}, n_done, 1);
  endtask

  initial begin
    bus.start = 1'b0; bus.dim = 2'd0;
    bus.a_base = 8'h00; bus.b_base = 8'h00; bus.c_base = 8'h00;
    clearLog();

    // Reset for two cycles, then idle with start low.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clearLog();
    repeat (20) @(negedge clk);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_outs", {bus.rd_en, bus.wr_en, bus.mac_clr, bus.mac_en, bus.done, bus.stall}, 0);
    checkOutput("rst_addr", {bus.a_addr, bus.b_addr, bus.c_addr}, 0);
    checkOutput("rst_idle_busy_cnt", n_busy, 0);
    checkOutput("rst_idle_done_cnt", n_done, 0);
`ifdef MAC_SEQ_PERF_CNT_EN
    checkOutput("rst_cycle_cnt", bus.cycle_cnt, 0);
`endif

    // N=2 basic sequence.
    clearLog();
    applyStimulus(2'd1, 8'h00, 8'h10, 8'h20);
    waitDone("n2", 40);
    checkN2("n2");
`ifdef MAC_SEQ_PERF_CNT_EN
    checkOutput("n2_cycle_cnt", bus.cycle_cnt, 16);
    repeat (10) @(negedge clk);
    checkOutput("n2_cycle_cnt_hold", bus.cycle_cnt, 16);
`endif

    // N=1 with bases 5/9/C.
    clearLog();
    applyStimulus(2'd0, 8'h05, 8'h09, 8'h0C);
    waitDone("n1", 20);
    checkOutput("n1_rd_cnt", rd_log.size(), 1);
    if (rd_log.size() > 0) checkOutput("n1_rd0", rd_log[0], 16'h0509);
    checkOutput("n1_macen_next", first_macen - first_rd, 1);
    checkOutput("n1_wr_cnt", wr_log.size(), 1);
    if (wr_log.size() > 0) checkOutput("n1_wr0", wr_log[0], 8'h0C);
    checkOutput("n1_busy_cnt", n_busy, 3);
    checkOutput("n1_done_at", done_cyc - first_busy, 3);

    // A second start during an N=2 run must be ignored completely.
    clearLog();
    applyStimulus(2'd1, 8'h00, 8'h10, 8'h20);
    repeat (5) @(posedge clk);
    #1;
    bus.dim = 2'd0; bus.a_base = 8'h77; bus.b_base = 8'h77; bus.c_base = 8'h77;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    waitDone("mid", 40);
    repeat (10) @(negedge clk);
    checkN2("mid");

    // Reset during the MAC state of the second element.
    clearLog();
    applyStimulus(2'd1, 8'h00, 8'h10, 8'h20);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_outs", {bus.rd_en, bus.wr_en, bus.mac_clr, bus.mac_en, bus.done, bus.busy}, 0);
    checkOutput("rstmid_addr", {bus.a_addr, bus.b_addr, bus.c_addr}, 0);
    repeat (20) @(negedge clk);
    checkOutput("rstmid_rd_cnt", rd_log.size(), 3);
    checkOutput("rstmid_wr_cnt", wr_log.size(), 1);
    checkOutput("rstmid_done_cnt", n_done, 0);
    clearLog();
    applyStimulus(2'd1, 8'h00, 8'h10, 8'h20);
    waitDone("rerun", 40);
    checkN2("rerun");

    // N=4 with the A and C bases close to the top of the address space.
    clearLog();
    applyStimulus(2'd3, 8'hFE, 8'h30, 8'hFC);
    waitDone("wrap", 200);
    checkOutput("wrap_rd_cnt", rd_log.size(), 64);
    if (rd_log.size() == 64) begin
      checkOutput("wrap_rd0", rd_log[0], 16'hFE30);
      checkOutput("wrap_rd1", rd_log[1], 16'hFF34);
      checkOutput("wrap_rd2", rd_log[2], 16'h0038);
      checkOutput("wrap_rd3", rd_log[3], 16'h013C);
      checkOutput("wrap_rd60", rd_log[60], 16'h0A33);
      checkOutput("wrap_rd63", rd_log[63], 16'h0D3F);
    end
    checkOutput("wrap_wr_cnt", wr_log.size(), 16);
    if (wr_log.size() == 16) begin
      checkOutput("wrap_wr0", wr_log[0], 8'hFC);
      checkOutput("wrap_wr4", wr_log[4], 8'h00);
      checkOutput("wrap_wr15", wr_log[15], 8'h0B);
    end
    checkOutput("wrap_busy_cnt", n_busy, 96);
    checkOutput("wrap_done_at", done_cyc - first_busy, 96);
`ifdef MAC_SEQ_PERF_CNT_EN
    checkOutput("wrap_cycle_cnt", bus.cycle_cnt, 96);
`endif

    checkOutput("inv_macen_follows_rd", macen_err, 0);
    checkOutput("inv_stall_eq_busy", stall_err, 0);
    checkOutput("inv_idle_quiet", idle_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net in case a wait somewhere never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
